mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Parametrised memory-interface engine for the multicycle MIPS core; it replaces the ad-hoc MAR/MDR registers and the direct enable/MOC wiring to memory.
- Accepts one load/store request per transaction and latches address and data (MAR/MDR function).
- Drives the asynchronous memory handshake: enable, rw, wait for MOC, release.
- Returns byte/half/word/(double) read data sign- or zero-extended, and flags misalignment or MOC timeout.

Parameters:
- DATA_W, 32, data bus width; legal values 32 or 64.
- ADDR_W, 32, byte-address width.
- TIMEOUT, 15, maximum cycles in ACCESS waiting for MOC before aborting; must be at least 1.
- BE_W, DATA_W/8, byte-enable width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  high only in IDLE.
- req_rw  in  1  1=read (load), 0=write (store).
- req_size  in  2  00 byte, 01 half, 10 word, 11 double (DATA_W=64 only).
- req_unsigned  in  1  zero-extend read data when high, sign-extend when low.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  extended load data; 0 for writes and errors.
- resp_err  out  1  valid with resp_valid: misaligned access or timeout.
- mem_enable  out  1  memory enable.
- mem_rw  out  1  1=read, 0=write.
- mem_addr  out  ADDR_W  latched address, low log2(BE_W) bits forced to 0.
- mem_wdata  out  DATA_W  lane-replicated store data.
- mem_be  out  BE_W  byte enables.
- mem_rdata  in  DATA_W  memory read data.
- mem_moc  in  1  memory operation complete; asynchronous to the request, so synchronised internally.

Behaviour:
- Reset (reset=0, async): state goes to IDLE. All outputs are 0 except req_ready=1. Internal MAR/MDR registers clear. Reset mid-transaction drops mem_enable immediately; no response is issued.
- mem_moc passes through a 2-flop synchroniser; all references to MOC below mean the synchronised value.
- States:
  - IDLE: req_ready=1. A request is accepted when req_valid=1 at a clock edge; req_* are latched. If aligned, go to ACCESS; otherwise go to RESP with err=1.
  - ACCESS: mem_enable=1 and mem_rw/addr/wdata/be are driven from the latches. A timeout counter increments each cycle.
    - MOC=1: for a read, capture the extended data into MDR; go to RELEASE.
    - Counter reaches TIMEOUT before MOC=1: go to RELEASE with err=1.
  - RELEASE: mem_enable=0; wait until MOC=0, then go to RESP.
  - RESP: resp_valid=1 for exactly one cycle with resp_rdata/resp_err; then go to IDLE.
- Alignment: half requires addr[0]=0, word requires addr[1:0]=0, double requires addr[2:0]=0. Size 11 when DATA_W=32 is an error.
- Lanes are little-endian; lane index = addr mod BE_W.
  - Byte: be = one-hot at lane; wdata = byte replicated across all lanes.
  - Half: be = 2'b11 shifted to lane; wdata = half replicated.
  - Word: when DATA_W=32, be is all-ones. When DATA_W=64, be is 0x0F or 0xF0 selected by addr[2], and the word is replicated.
  - Read: select the addressed lane(s), then extend to DATA_W according to req_unsigned.
- Latency:
  - Aligned request: resp_valid is asserted 3 cycles after accept (synchroniser delay) plus N memory wait cycles plus release wait.
  - Misaligned request: resp_valid is asserted the cycle after accept; the memory is never touched.
- Back-to-back requests: a new request can be accepted in the cycle after resp_valid, i.e. when state is IDLE again.
- A timeout during a write reports err=1 and makes no retry.
- MOC already high on entry to ACCESS: counts as completion (no edge detection required).
- req_* inputs are ignored outside IDLE.

Decomposition:
- Shared package mem_pkg:
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DOUBLE.
  - State encoding (IDLE/ACCESS/RELEASE/RESP).
  - RW_READ=1 / RW_WRITE=0.
- One sub-module: mem_lane_align, purely combinational. It generates be/wdata replication on the store side and selects and extends read data on the load side. The FSM, synchroniser, timeout counter and MAR/MDR registers stay in the top module.

Test Plan:
- Word read, DATA_W=32: addr=0x10, memory returns 0xDEADBEEF with MOC 2 cycles after enable → resp_rdata=0xDEADBEEF, err=0, mem_be=4'b1111, mem_addr=0x10.
- Signed/unsigned byte read: memory word 0x80FF7F01 at 0x20, read byte at 0x23 → signed 0xFFFFFF80, unsigned 0x00000080.
- Half write: addr=0x42, wdata=0x1234ABCD → mem_addr=0x40, mem_be=4'b1100, mem_wdata=0xABCDABCD, mem_rw=0.
- Misaligned word read at 0x06 → resp_valid the cycle after accept, err=1, mem_enable never asserted.
- Timeout: TIMEOUT=15 and MOC held low → mem_enable drops after 15 ACCESS cycles, resp err=1, rdata=0.
- Async reset asserted during ACCESS → mem_enable=0 immediately, req_ready=1, no resp_valid; the next word read at 0x0 completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: transfer sizes, FSM states,
// read/write polarity and the alignment rule used at request acceptance.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE   = 2'b00;
   localparam logic [1:0] SZ_HALF   = 2'b01;
   localparam logic [1:0] SZ_WORD   = 2'b10;
   localparam logic [1:0] SZ_DOUBLE = 2'b11;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_RELEASE = 2'd2,
      ST_RESP    = 2'd3
   } state_t;

   // Doubles only exist on a 64-bit bus; on a 32-bit bus they are rejected here.
   function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] lo,
                                       input logic wide);
      logic ok;
      case (size)
         SZ_BYTE: ok = 1'b1;
         SZ_HALF: ok = (lo[0] == 1'b0);
         SZ_WORD: ok = (lo[1:0] == 2'b00);
         default: ok = wide && (lo == 3'b000);
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane steering: byte enables and store-data replication on the
// way out, lane selection plus sign/zero extension on the way back.
module mem_lane_align
   import mem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int BE_W   = DATA_W / 8,
   parameter int LANE_W = $clog2(BE_W)
) (
   input  logic [LANE_W-1:0] lane,
   input  logic [1:0]        size,
   input  logic              is_unsigned,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata,
   output logic [BE_W-1:0]   be,
   output logic [DATA_W-1:0] wdata_rep,
   output logic [DATA_W-1:0] rdata_ext
);

   logic [DATA_W-1:0] shifted;

   // Aligned accesses keep the low lane bits clear, so shifting a fixed-width
   // enable pattern by the lane index covers every size on either bus width.
   always_comb begin
      shifted   = rdata >> {lane, 3'b000};
      be        = '0;
      wdata_rep = '0;
      rdata_ext = '0;
      case (size)
         SZ_BYTE: begin
            be        = BE_W'(1) << lane;
            wdata_rep = {BE_W{wdata[7:0]}};
            if (is_unsigned) rdata_ext = DATA_W'(shifted[7:0]);
            else             rdata_ext = DATA_W'($signed(shifted[7:0]));
         end
         SZ_HALF: begin
            be        = BE_W'(2'b11) << lane;
            wdata_rep = {(BE_W/2){wdata[15:0]}};
            if (is_unsigned) rdata_ext = DATA_W'(shifted[15:0]);
            else             rdata_ext = DATA_W'($signed(shifted[15:0]));
         end
         SZ_WORD: begin
            be        = BE_W'(4'hF) << lane;
            wdata_rep = {(BE_W/4){wdata[31:0]}};
            if (is_unsigned) rdata_ext = DATA_W'(shifted[31:0]);
            else             rdata_ext = DATA_W'($signed(shifted[31:0]));
         end
         default: begin
            be        = '1;
            wdata_rep = wdata;
            rdata_ext = rdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store engine for the multicycle core: latches MAR/MDR, runs the
// enable/MOC handshake with a timeout, and returns extended read data.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 15,
   parameter int BE_W    = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rw,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              mem_enable,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [BE_W-1:0]   mem_be,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_moc
);

   localparam int LANE_W = $clog2(BE_W);
   localparam int TW     = $clog2(TIMEOUT + 1);

   state_t            state, state_nx;
   logic [1:0]        moc_sync;
   logic              moc;
   logic              aligned;
   logic              timed_out;
   logic [ADDR_W-1:0] mar;
   logic [DATA_W-1:0] mdr_w, mdr_r;
   logic              rw_q, uns_q, err_q;
   logic [1:0]        size_q;
   logic [TW-1:0]     tcount;
   logic [BE_W-1:0]   be_lane;
   logic [DATA_W-1:0] wdata_lane, rdata_ext;

   assign moc       = moc_sync[1];
   assign aligned   = is_aligned(req_size, req_addr[2:0], DATA_W == 64);
   assign timed_out = (tcount == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) moc_sync <= '0;
      else        moc_sync <= {moc_sync[0], mem_moc};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // Memory-side outputs are gated by ACCESS so a reset drops them at once.
   always_comb begin
      state_nx   = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      resp_err   = 1'b0;
      mem_enable = 1'b0;
      mem_rw     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_be     = '0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nx = aligned ? ST_ACCESS : ST_RESP;
         end
         ST_ACCESS: begin
            mem_enable = 1'b1;
            mem_rw     = rw_q;
            mem_addr   = {mar[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
            mem_wdata  = wdata_lane;
            mem_be     = be_lane;
            if (moc || timed_out) state_nx = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (!moc) state_nx = ST_RESP;
         end
         default: begin
            resp_valid = 1'b1;
            resp_rdata = mdr_r;
            resp_err   = err_q;
            state_nx   = ST_IDLE;
         end
      endcase
   end

   // MAR/MDR latches and the MOC wait counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mar    <= '0;
         mdr_w  <= '0;
         mdr_r  <= '0;
         rw_q   <= 1'b0;
         uns_q  <= 1'b0;
         size_q <= SZ_BYTE;
         err_q  <= 1'b0;
         tcount <= '0;
      end else if (state == ST_IDLE) begin
         if (req_valid) begin
            mar    <= req_addr;
            mdr_w  <= req_wdata;
            mdr_r  <= '0;
            rw_q   <= req_rw;
            uns_q  <= req_unsigned;
            size_q <= req_size;
            err_q  <= !aligned;
            tcount <= '0;
         end
      end else if (state == ST_ACCESS) begin
         if (moc) begin
            if (rw_q == RW_READ) mdr_r <= rdata_ext;
         end else if (timed_out) begin
            err_q <= 1'b1;
         end else begin
            tcount <= tcount + 1'b1;
         end
      end
   end

   mem_lane_align #(
      .DATA_W (DATA_W),
      .BE_W   (BE_W),
      .LANE_W (LANE_W)
   ) u_lane_align (
      .lane        (mar[LANE_W-1:0]),
      .size        (size_q),
      .is_unsigned (uns_q),
      .wdata       (mdr_w),
      .rdata       (mem_rdata),
      .be          (be_lane),
      .wdata_rep   (wdata_lane),
      .rdata_ext   (rdata_ext)
   );

endmodule
